// File: rtl/hazard_pkg.sv
// Shared constants and helpers for the load-use hazard scoreboard.
package hazard_pkg;

  // x0 is hardwired to zero and never creates a dependency.
  localparam int ZERO_REG = 0;

  // Default register-file address width (32 architectural registers).
  localparam int DEFAULT_REG_ADDR_W = 5;

  // Bits needed to hold the value lat, i.e. clog2(lat+1).
  // The result is never below 1, so LOAD_LAT=0 still gives a legal vector.
  function automatic int cnt_width(input int lat);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) <= lat) begin
        w = i + 1;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/load_hazard_scoreboard_pending_timer.sv
// One scoreboard entry: counts down the cycles until an in-flight load
// result can be consumed. A new load to the same register reloads the count.
module pending_timer #(
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic busy
);

  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;

  // Reload wins over the decrement; otherwise count down and park at zero.
  always_comb begin
    cnt_next = cnt_reg;
    if (load) begin
      cnt_next = CNT_W'(LOAD_LAT);
    end else if (cnt_reg != '0) begin
      cnt_next = cnt_reg - CNT_W'(1);
    end
  end

  // Countdown register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign busy = (cnt_reg != '0);

endmodule

// File: rtl/load_hazard_scoreboard.sv
// Load-use hazard unit. Keeps one countdown per architectural register for
// in-flight loads and stalls the instruction in IF/ID while any source it
// actually reads is still pending. Also counts stall cycles (saturating).
module load_hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = DEFAULT_REG_ADDR_W,
  parameter int LOAD_LAT   = 1,
  parameter int PERF_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  issue_valid_IF_ID,
  input  logic                  mem_read_IF_ID,
  input  logic [REG_ADDR_W-1:0] RegisterRd_IF_ID,
  input  logic [REG_ADDR_W-1:0] RegisterRs1_IF_ID,
  input  logic [REG_ADDR_W-1:0] RegisterRs2_IF_ID,
  input  logic                  rs1_used_IF_ID,
  input  logic                  rs2_used_IF_ID,
  input  logic                  flush_ID_EX,
  output logic                  stall,
  output logic [PERF_W-1:0]     stall_cycles
);

  localparam int NUM_REGS = 1 << REG_ADDR_W;
  localparam int CNT_W    = cnt_width(LOAD_LAT);
  localparam logic [REG_ADDR_W-1:0] ZERO_ADDR = REG_ADDR_W'(ZERO_REG);

  logic [NUM_REGS-1:0] busy_vec;
  logic                rs1_hazard;
  logic                rs2_hazard;
  logic                load_issue;
  logic [PERF_W-1:0]   stall_cycles_reg;
  logic [PERF_W-1:0]   stall_cycles_next;

  // One timer per register; x0 has no timer and is never busy.
  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_entry
      if (gi == ZERO_REG) begin : g_zero
        assign busy_vec[gi] = 1'b0;
      end else begin : g_timer
        pending_timer #(
          .LOAD_LAT (LOAD_LAT),
          .CNT_W    (CNT_W)
        ) u_timer (
          .clk   (clk),
          .rst_n (rst_n),
          .load  (load_issue && (RegisterRd_IF_ID == REG_ADDR_W'(gi))),
          .busy  (busy_vec[gi])
        );
      end
    end
  endgenerate

  // A source is hazardous only if it is a real register, actually read,
  // and still has a load in flight.
  assign rs1_hazard = rs1_used_IF_ID && (RegisterRs1_IF_ID != ZERO_ADDR)
                      && busy_vec[RegisterRs1_IF_ID];
  assign rs2_hazard = rs2_used_IF_ID && (RegisterRs2_IF_ID != ZERO_ADDR)
                      && busy_vec[RegisterRs2_IF_ID];

  // Held low during reset so a stale scoreboard cannot freeze the front end.
  assign stall = rst_n && issue_valid_IF_ID && (rs1_hazard || rs2_hazard);

  // Only a load that really leaves ID (not stalled, not squashed) is tracked.
  assign load_issue = issue_valid_IF_ID && !stall && !flush_ID_EX
                      && mem_read_IF_ID && (RegisterRd_IF_ID != ZERO_ADDR);

  // Saturating stall-cycle counter: sticks at all-ones instead of wrapping.
  always_comb begin
    stall_cycles_next = stall_cycles_reg;
    if (stall && (stall_cycles_reg != '1)) begin
      stall_cycles_next = stall_cycles_reg + PERF_W'(1);
    end
  end

  // Performance counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cycles_reg <= '0;
    end else begin
      stall_cycles_reg <= stall_cycles_next;
    end
  end

  assign stall_cycles = stall_cycles_reg;

endmodule

// File: doc/load_hazard_scoreboard.md
# load_hazard_scoreboard

Parametrised load-use hazard unit for the pipelined RISC-V core; sits beside the IF/ID register and drives the pipeline stall. Rather than comparing against the single ID/EX destination, it keeps a per-register countdown scoreboard of in-flight loads. This lets memory latency beyond one cycle be covered without extra compare logic. It also ignores x0 and unused source operands, squashes flushed issues, and keeps a saturating stall-cycle performance counter.

## Interface

Parameters:

- REG_ADDR_W, 5: register address width; scoreboard has 2**REG_ADDR_W entries.
- LOAD_LAT, 1: cycles after a load leaves ID during which a consumer in ID must stall (1 = classic 5-stage load-use).
- PERF_W, 32: width of the stall-cycle counter.

Ports:

- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- issue_valid_IF_ID  in  1  IF/ID holds a valid instruction.
- mem_read_IF_ID  in  1  that instruction is a load.
- RegisterRd_IF_ID  in  REG_ADDR_W  its destination.
- RegisterRs1_IF_ID  in  REG_ADDR_W  source 1.
- RegisterRs2_IF_ID  in  REG_ADDR_W  source 2.
- rs1_used_IF_ID  in  1  source 1 is actually read.
- rs2_used_IF_ID  in  1  source 2 is actually read.
- flush_ID_EX  in  1  instruction leaving ID this cycle is squashed (branch taken).
- stall  out  1  hold PC and IF/ID, insert bubble into ID/EX.
- stall_cycles  out  PERF_W  saturating count of cycles with stall=1.

## Operation

- State: cnt[r] for every register r, width clog2(LOAD_LAT+1); stall_cycles.
- Hazard on a source s: s != 0 and used and cnt[s] != 0.
- stall = issue_valid_IF_ID and (hazard on rs1 or hazard on rs2).
- stall is purely combinational from current state and inputs.
- Issue event = issue_valid_IF_ID and !stall and !flush_ID_EX.
- Load issue = issue event and mem_read_IF_ID and RegisterRd_IF_ID != 0.
- Per cycle, for each r:
  - if load issue targets r, cnt[r] <= LOAD_LAT;
  - else if cnt[r] != 0, cnt[r] <= cnt[r] - 1.
- Same-register collision: a load issue to r overrides that cycle's decrement of r.
- A stalled or flushed instruction never writes the scoreboard.
- Flush does not clear existing entries; older loads still complete.
- cnt[0] is never written; it stays 0.
- stall_cycles increments when stall=1 and holds at all-ones (no wrap).
- LOAD_LAT=0 is legal: stall is constant 0 and the scoreboard is unused.

## Timing

- Reset (rst_n=0 at an edge): all cnt=0, stall_cycles=0.
- stall=0 while rst_n=0 and in the cycle after reset.
- Reset mid-stall clears all pending loads; no stall on the following cycle.
- Load issues at cycle t; dependent sits in IF/ID from t+1:
  - stall=1 for cycles t+1 … t+LOAD_LAT;
  - stall=0 at t+LOAD_LAT+1, when the dependent issues.
- A dependent arriving k cycles after the load stalls max(0, LOAD_LAT-k+1) cycles.
- Two back-to-back loads to different registers are tracked independently.
- stall_cycles lags stall by one cycle (registered).

## Structure

- Shared package/header hazard_pkg:
  - ZERO_REG = 0;
  - default REG_ADDR_W;
  - function computing the counter width from LOAD_LAT.
- One natural sub-module: pending_timer, a single scoreboard entry with:
  - load-with-LOAD_LAT, decrement-to-zero and busy output;
  - instantiated per register via generate, entry 0 tied off.
- Top level holds the rs1/rs2 busy multiplexers, issue gating and perf counter.

## Test plan

- LOAD_LAT=1: lw x5 issues, then add x6,x5,x1 -> stall=1 exactly one cycle, stall_cycles=1.
- LOAD_LAT=3: lw x7, then consumer of x7 two cycles later -> stall=1 for 2 cycles, then 0.
- lw x0, or consumer with rs2=x5 but rs2_used=0 -> stall never asserts.
- lw x9 issued with flush_ID_EX=1, then consumer of x9 -> no stall.
- LOAD_LAT=2: lw x3 at t, lw x3 at t+1 -> cnt[x3] reloads to 2; consumer of x3 at t+2 stalls 2 cycles.
- Stall held with stall_cycles preset near all-ones (PERF_W=4): counts to 15 and holds.
- Assert rst_n=0 during a stall -> stall=0 and stall_cycles=0 after the edge; consumer then issues.
